// File: rtl/irst_rekey_ctrl_pkg.sv
// Shared mips_16 definitions for the instruction re-key controller.
// Holds the FSM state encoding, the instruction-memory address width default,
// the default re-keyed image depth and the default halt timeout.
// No ports: package only.
package irst_rekey_ctrl_pkg;

    localparam int unsigned KeyW           = 16;
    localparam int unsigned PcWidthDef     = 8;
    localparam int unsigned ImemDepthDef   = 256;
    localparam int unsigned HaltTimeoutDef = 64;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StHalt   = 3'd1,
        StRead   = 3'd2,
        StWrite  = 3'd3,
        StSwap   = 3'd4,
        StFinish = 3'd5
    } rekey_state_e;

    // The timer only has to count up to timeout-1.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/irst_rekey_ctrl.sv
// Instruction-memory re-key controller.
// On an accepted rekey_req it halts the core, waits for core_idle, then walks
// the instruction image word by word (read, then write back
// word ^ old_key ^ new_key) and only afterwards swaps the active key, so the
// core never fetches an image that disagrees with the key in use.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-low reset
//   rekey_req     re-randomization request, only looked at in IDLE
//   new_key       key to apply, latched with an accepted request
//   core_idle     core pipeline drained and stalled
//   imem_rd_data  instruction-memory read data, one-cycle latency
//   key           active key (randomizer rand_data[15:0])
//   core_halt     stall request to the core / IF stage
//   imem_addr     instruction-memory address
//   imem_rd_en    read strobe
//   imem_wr_en    write strobe
//   imem_wr_data  re-keyed word
//   busy          high whenever not IDLE
//   done          one-cycle pulse on successful completion
//   timeout_err   one-cycle pulse when the halt wait is abandoned
module irst_rekey_ctrl
    import irst_rekey_ctrl_pkg::*;
#(
    parameter int unsigned      PC_WIDTH     = PcWidthDef,
    parameter int unsigned      IMEM_DEPTH   = ImemDepthDef,
    parameter logic [KeyW-1:0]  RESET_KEY    = 16'h0000,
    parameter int unsigned      HALT_TIMEOUT = HaltTimeoutDef
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rekey_req,
    input  logic [KeyW-1:0]     new_key,
    input  logic                core_idle,
    input  logic [KeyW-1:0]     imem_rd_data,
    output logic [KeyW-1:0]     key,
    output logic                core_halt,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_rd_en,
    output logic                imem_wr_en,
    output logic [KeyW-1:0]     imem_wr_data,
    output logic                busy,
    output logic                done,
    output logic                timeout_err
);

    localparam int unsigned         TimerW   = timer_width(HALT_TIMEOUT);
    localparam logic [PC_WIDTH-1:0] LastAddr = PC_WIDTH'(IMEM_DEPTH - 1);
    localparam logic [TimerW-1:0]   LastTick = TimerW'(HALT_TIMEOUT - 1);

    rekey_state_e        state_q;
    logic [PC_WIDTH-1:0] addr_q;
    logic [TimerW-1:0]   timer_q;
    logic [KeyW-1:0]     key_q;
    logic [KeyW-1:0]     pending_q;
    logic                core_halt_q;
    logic                rd_en_q;
    logic                wr_en_q;
    logic                busy_q;
    logic                done_q;

    logic                halt_expire;

    // Last HALT cycle with the core still running: abandon the attempt.
    assign halt_expire = (state_q == StHalt) && !core_idle && (timer_q == LastTick);

    // Registered outputs are set on the edge that enters the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            timer_q     <= '0;
            key_q       <= RESET_KEY;
            pending_q   <= RESET_KEY;
            core_halt_q <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rekey_req) begin
                        pending_q <= new_key;
                        addr_q    <= '0;
                        timer_q   <= '0;
                        busy_q    <= 1'b1;
                        if (new_key == key_q) begin
                            // Nothing to re-key: skip the halt and memory walk.
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= StHalt;
                            core_halt_q <= 1'b1;
                        end
                    end
                end

                StHalt: begin
                    timer_q <= timer_q + TimerW'(1);
                    if (core_idle) begin
                        state_q <= StRead;
                        rd_en_q <= 1'b1;
                    end else if (timer_q == LastTick) begin
                        state_q     <= StIdle;
                        core_halt_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end

                StRead: begin
                    state_q <= StWrite;
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b1;
                end

                StWrite: begin
                    wr_en_q <= 1'b0;
                    if (addr_q == LastAddr) begin
                        // Address holds at the last word; it never wraps.
                        state_q <= StSwap;
                    end else begin
                        addr_q  <= addr_q + PC_WIDTH'(1);
                        state_q <= StRead;
                        rd_en_q <= 1'b1;
                    end
                end

                StSwap: begin
                    key_q       <= pending_q;
                    state_q     <= StFinish;
                    core_halt_q <= 1'b0;
                    done_q      <= 1'b1;
                end

                StFinish: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q     <= StIdle;
                    core_halt_q <= 1'b0;
                    rd_en_q     <= 1'b0;
                    wr_en_q     <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign key         = key_q;
    assign core_halt   = core_halt_q;
    assign imem_addr   = addr_q;
    assign imem_rd_en  = rd_en_q;
    assign imem_wr_en  = wr_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = halt_expire;

    // Read data arrives in the WRITE cycle, so the re-keyed word is formed combinationally.
    assign imem_wr_data = wr_en_q ? (imem_rd_data ^ key_q ^ pending_q) : '0;

endmodule

// File: tb/tb_irst_rekey_ctrl.sv
module tb_irst_rekey_ctrl;

    localparam int unsigned PcW   = 8;
    localparam int unsigned Depth = 4;
    localparam int unsigned Tmo   = 64;

    localparam int EvWrite = 0;
    localparam int EvDone  = 1;
    localparam int EvTmo   = 2;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           rekey_req = 1'b0;
    logic [15:0]    new_key = 16'h0000;
    logic           core_idle = 1'b0;
    logic [15:0]    imem_rd_data = 16'h0000;
    logic [15:0]    key;
    logic           core_halt;
    logic [PcW-1:0] imem_addr;
    logic           imem_rd_en;
    logic           imem_wr_en;
    logic [15:0]    imem_wr_data;
    logic           busy;
    logic           done;
    logic           timeout_err;

    int errors = 0;
    int checks = 0;

    ev_t sb[$];

    logic [15:0] mem [Depth];

    int  busy_cnt = 0;
    int  last_busy = 0;
    int  halt_cnt = 0;
    bit  halt_seen = 1'b0;
    bit  strobe_seen = 1'b0;

    irst_rekey_ctrl #(
        .PC_WIDTH    (PcW),
        .IMEM_DEPTH  (Depth),
        .RESET_KEY   (16'h0000),
        .HALT_TIMEOUT(Tmo)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rekey_req   (rekey_req),
        .new_key     (new_key),
        .core_idle   (core_idle),
        .imem_rd_data(imem_rd_data),
        .key         (key),
        .core_halt   (core_halt),
        .imem_addr   (imem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_wr_en  (imem_wr_en),
        .imem_wr_data(imem_wr_data),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Instruction memory with one-cycle read latency.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rd_data <= mem[imem_addr[1:0]];
        if (imem_wr_en) mem[imem_addr[1:0]] <= imem_wr_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = EvWrite;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_ev(input int kind, input logic [15:0] k);
        ev_t e;
        e.kind = kind;
        e.addr = '0;
        e.data = k;
        sb.push_back(e);
    endtask

    task automatic wait_evt(input int bound);
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk);
            if (done || timeout_err) return;
        end
        errors++;
        checks++;
        $display("FAIL wait_evt: no done/timeout within %0d cycles", bound);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write, done or timeout.
    always @(negedge clk) begin
        ev_t e;
        if (imem_rd_en || imem_wr_en) begin
            strobe_seen = 1'b1;
            chk("rd_wr_exclusive", {31'd0, imem_rd_en & imem_wr_en}, 32'd0);
        end
        if (core_halt) begin
            halt_seen = 1'b1;
            halt_cnt++;
        end else begin
            halt_cnt = 0;
        end
        if (busy) begin
            busy_cnt++;
        end else if (busy_cnt != 0) begin
            last_busy = busy_cnt;
            busy_cnt  = 0;
        end
        if (imem_wr_en || done || timeout_err) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_event: wr=%0b done=%0b tmo=%0b with empty scoreboard",
                         imem_wr_en, done, timeout_err);
            end else begin
                e = sb.pop_front();
                if (imem_wr_en) begin
                    chk("ev_kind_write", EvWrite, e.kind);
                    chk("wr_addr", {24'd0, imem_addr}, {24'd0, e.addr});
                    chk("wr_data", {16'd0, imem_wr_data}, {16'd0, e.data});
                end else if (done) begin
                    chk("ev_kind_done", EvDone, e.kind);
                    chk("done_key", {16'd0, key}, {16'd0, e.data});
                    chk("done_halt_low", {31'd0, core_halt}, 32'd0);
                end else begin
                    chk("ev_kind_tmo", EvTmo, e.kind);
                    chk("tmo_key", {16'd0, key}, {16'd0, e.data});
                    chk("tmo_halt_cycle", halt_cnt, Tmo);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        mem[0] = 16'h0001;
        mem[1] = 16'h0002;
        mem[2] = 16'h0003;
        mem[3] = 16'h0004;

        // Reset state.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key", {16'd0, key}, 32'h0000);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halt", {31'd0, core_halt}, 32'd0);
        chk("rst_strobes", {30'd0, imem_rd_en, imem_wr_en}, 32'd0);
        chk("rst_done_tmo", {30'd0, done, timeout_err}, 32'd0);
        chk("rst_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_wr_data", {16'd0, imem_wr_data}, 32'd0);
        rst = 1'b1;

        // Run 1: key 0000 -> A5A5, core idle in third HALT cycle.
        push_wr(8'd0, 16'hA5A4);
        push_wr(8'd1, 16'hA5A7);
        push_wr(8'd2, 16'hA5A6);
        push_wr(8'd3, 16'hA5A1);
        push_ev(EvDone, 16'hA5A5);
        @(posedge clk); #1 new_key = 16'hA5A5; rekey_req = 1'b1;
        @(posedge clk); #1 rekey_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 core_idle = 1'b1;
        wait_evt(100);
        core_idle = 1'b0;
        repeat (2) @(negedge clk);
        chk("run1_busy_len", last_busy, 13);
        chk("run1_key", {16'd0, key}, 32'h0000A5A5);

        // Run 2: A5A5 -> 0F0F, each word flips by AAAA.
        push_wr(8'd0, 16'h0F0E);
        push_wr(8'd1, 16'h0F0D);
        push_wr(8'd2, 16'h0F0C);
        push_wr(8'd3, 16'h0F0B);
        push_ev(EvDone, 16'h0F0F);
        @(posedge clk); #1 new_key = 16'h0F0F; rekey_req = 1'b1;
        @(posedge clk); #1 rekey_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 core_idle = 1'b1;
        wait_evt(100);
        core_idle = 1'b0;
        repeat (2) @(negedge clk);
        chk("run2_busy_len", last_busy, 13);

        // Run 3: new_key equal to key -> straight to FINISH.
        push_ev(EvDone, 16'h0F0F);
        @(posedge clk); #1 new_key = 16'h0F0F; rekey_req = 1'b1;
        halt_seen = 1'b0;
        strobe_seen = 1'b0;
        @(negedge clk);
        chk("eq_done_cycle1", {31'd0, done}, 32'd0);
        @(posedge clk); #1 rekey_req = 1'b0;
        @(negedge clk);
        chk("eq_done_cycle2", {31'd0, done}, 32'd1);
        repeat (2) @(negedge clk);
        chk("eq_no_halt", {31'd0, halt_seen}, 32'd0);
        chk("eq_no_strobes", {31'd0, strobe_seen}, 32'd0);

        // Run 4: core never idles -> timeout after 64 HALT cycles.
        push_ev(EvTmo, 16'h0F0F);
        strobe_seen = 1'b0;
        @(posedge clk); #1 new_key = 16'h1234; rekey_req = 1'b1;
        @(posedge clk); #1 rekey_req = 1'b0;
        wait_evt(200);
        repeat (2) @(negedge clk);
        chk("tmo_key_after", {16'd0, key}, 32'h00000F0F);
        chk("tmo_busy_after", {31'd0, busy}, 32'd0);
        chk("tmo_halt_after", {31'd0, core_halt}, 32'd0);
        chk("tmo_busy_len", last_busy, Tmo);
        chk("tmo_no_strobes", {31'd0, strobe_seen}, 32'd0);

        // Run 5: reset during WRITE of addr 2; a request while busy is ignored.
        push_wr(8'd0, 16'h5554);
        push_wr(8'd1, 16'h5557);
        push_wr(8'd2, 16'h5556);
        @(posedge clk); #1 new_key = 16'h5555; rekey_req = 1'b1;
        @(posedge clk); #1 new_key = 16'h0000;
        @(posedge clk); #1 rekey_req = 1'b0;
        @(posedge clk); #1 core_idle = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (imem_wr_en && imem_addr == 8'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_mid_write2_seen", {31'd0, found}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        strobe_seen = 1'b0;
        halt_seen = 1'b0;
        rst = 1'b1;
        core_idle = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_mid_no_strobes", {31'd0, strobe_seen}, 32'd0);
        chk("rst_mid_no_halt", {31'd0, halt_seen}, 32'd0);
        chk("rst_mid_key", {16'd0, key}, 32'h0000);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_addr", {24'd0, imem_addr}, 32'd0);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
